boron_key_sequencer: RTL and testbench
======================================

Name: boron_key_sequencer

Overview:
- Upstream stage of the BORON key schedule.
- Accepts an 80-bit master key and iterates the key-register update for all rounds.
- Streams the 26 round keys (K0..K25, 64 bits each) to the round datapath over a valid/ready handshake, one per accepted transfer.
- Holds the 80-bit key register and the 5-bit round counter that drive the per-round key update.

Parameters:
- NUM_ROUNDS, 25, index of the last round key emitted; total keys = NUM_ROUNDS+1.
- KEY_W, 80, master key / key register width (fixed 80; not intended to change).
- RK_W, 64, round key width = key_reg[63:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  80  master key.
- key_valid  input  1  key_in valid.
- key_ready  output  1  sequencer can accept a key (IDLE only).
- abort  input  1  synchronous flush back to IDLE.
- rk_data  output  64  current round key.
- rk_index  output  5  round number of rk_data (0..NUM_ROUNDS).
- rk_last  output  1  rk_data is K[NUM_ROUNDS].
- rk_valid  output  1  rk_data valid.
- rk_ready  input  1  consumer accepts rk_data.
- busy  output  1  high while in RUN.

Behaviour:
- Reset state (async): state=IDLE, key_reg=0, round=0, rk_valid=0, rk_last=0, busy=0, key_ready=1, rk_data=0, rk_index=0.
- FSM has two states: IDLE and RUN.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid=1, on the next edge: key_reg<=key_in, round<=0, state<=RUN.
- RUN:
  - key_ready=0, busy=1, rk_valid=1.
  - rk_data=key_reg[63:0], rk_index=round, rk_last=(round==NUM_ROUNDS).
- Transfer occurs on rk_valid&rk_ready at a clock edge:
  - If round==NUM_ROUNDS: state<=IDLE, key_reg held.
  - Else: key_reg<=UPD(key_reg, round), round<=round+1.
- Key update UPD(k, r), evaluated in this order:
  - t = {k[66:0], k[79:67]} (rotate left 13).
  - t[3:0] = S(t[3:0]).
  - t[63:59] ^= r[4:0].
  - All other bits of t pass through unchanged.
- S-box S(x), for x=0..F: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- Latency:
  - K0 is presented the cycle after key acceptance.
  - Each subsequent key is presented the cycle after the previous transfer.
  - With rk_ready held high, all 26 keys take 26 cycles, and key_ready returns 1 in the cycle after the K25 transfer.
- Output stability: while rk_valid=1 and rk_ready=0, rk_data, rk_index and rk_last are held stable (no update, no drop).
- Outputs are driven from registers or state only; there is no combinational path from rk_ready to rk_valid or rk_data.
- A new key is not accepted in RUN. key_valid asserted in RUN is ignored, and key_in must be held by the producer.
- abort=1:
  - From any state, abort forces state<=IDLE, round<=0 on the next edge. abort has priority over a simultaneous transfer.
  - In IDLE, abort has priority over key_valid: the key is not accepted.
- Async reset mid-RUN drops all outputs to their reset values immediately. No partial key is emitted after reset release.
- Round counter arithmetic is 5-bit unsigned and never wraps, since its maximum is NUM_ROUNDS=25.

Test Plan:
- Zero key, rk_ready=1:
  - Expect K0=0x0000000000000000.
  - Expect K1=0x000000000000000E.
  - Expect K2=0x080000000001C00E.
  - rk_index runs 0..25; rk_last high only with index 25.
  - key_ready=1 one cycle after the K25 transfer.
- Backpressure: hold rk_ready=0 for 5 cycles at index 3 -> rk_data and rk_index stay constant. On release, K3 transfers once and K4 follows; no duplicate or skipped index.
- Load 0xFFFFFFFFFFFFFFFFFFFF then key_valid held during RUN -> key_in ignored until IDLE. K0=0xFFFFFFFFFFFFFFFF; K1 low nibble = S(F)=6, and K1[63:59]=0x1F.
- Assert abort at index 10 together with rk_ready=1 -> no transfer counted, IDLE next cycle, key_ready=1. A reload restarts at index 0 with the new key.
- Assert async rst mid-RUN (index 7), between clock edges -> rk_valid=0, busy=0 immediately. After release, the zero-key sequence from the first scenario reproduces exactly.
- Random rk_ready (~50%) over 20 random keys -> a scoreboard of the 26 keys per master key matches a software UPD model bit-exactly.

Source files
------------

// File: rtl/boron_key_sequencer.sv
// Purpose : BORON key-schedule front end; loads an 80-bit master key and streams round keys K0..K[NUM_ROUNDS].
// Latency : K0 is valid the cycle after key acceptance; each later key the cycle after the previous transfer.
// Backpressure: rk_data/rk_index/rk_last hold while rk_valid && !rk_ready; key_ready is low for the whole run.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   key_in, key_valid   master key offer; taken in IDLE when abort is low
//   key_ready           high in IDLE only
//   abort               synchronous flush to IDLE (beats transfer and key load)
//   rk_data, rk_index,  round key (key_reg[63:0]), its round number and a
//   rk_last             flag marking the final key
//   rk_valid, rk_ready  round-key handshake
//   busy                high while a key is being sequenced
module boron_key_sequencer #(
    parameter int NUM_ROUNDS = 25,
    parameter int KEY_W      = 80,
    parameter int RK_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             abort,
    output logic [RK_W-1:0]  rk_data,
    output logic [4:0]       rk_index,
    output logic             rk_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] key_reg;
    logic [4:0]       round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hE;
            4'h1:    y = 4'h4;
            4'h2:    y = 4'hB;
            4'h3:    y = 4'h1;
            4'h4:    y = 4'h7;
            4'h5:    y = 4'h9;
            4'h6:    y = 4'hC;
            4'h7:    y = 4'hA;
            4'h8:    y = 4'hD;
            4'h9:    y = 4'h2;
            4'hA:    y = 4'h0;
            4'hB:    y = 4'hF;
            4'hC:    y = 4'h8;
            4'hD:    y = 4'h5;
            4'hE:    y = 4'h3;
            default: y = 4'h6;
        endcase
        return y;
    endfunction

    // Rotate left 13, substitute the low nibble, then mix the round number
    // into bits 63:59. The order matters: the S-box sees post-rotation bits.
    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = sbox(t[3:0]);
        t[63:59] = t[63:59] ^ r;
        return t;
    endfunction

    // Round key and index come straight from the working registers, so they
    // cannot change unless a transfer (or abort/reset) updates those registers.
    assign rk_data  = key_reg[RK_W-1:0];
    assign rk_index = round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_reg   <= '0;
            round     <= '0;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
        end else if (abort) begin
            // key_reg is left alone; it is reloaded before it is shown again.
            state     <= ST_IDLE;
            round     <= '0;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        state     <= ST_RUN;
                        key_reg   <= key_in;
                        round     <= '0;
                        rk_valid  <= 1'b1;
                        rk_last   <= (LAST_ROUND == 5'd0);
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rk_valid && rk_ready) begin
                        if (round == LAST_ROUND) begin
                            // Final key consumed; key_reg keeps K[last].
                            state     <= ST_IDLE;
                            rk_valid  <= 1'b0;
                            rk_last   <= 1'b0;
                            busy      <= 1'b0;
                            key_ready <= 1'b1;
                        end else begin
                            key_reg <= key_upd(key_reg, round);
                            round   <= round + 5'd1;
                            rk_last <= ((round + 5'd1) == LAST_ROUND);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rk_valid  <= 1'b0;
                    rk_last   <= 1'b0;
                    busy      <= 1'b0;
                    key_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boron_key_sequencer.sv
// Purpose : self-checking bench for boron_key_sequencer against a software key-schedule model.
// Latency : inputs driven 1 ns after each rising edge, outputs sampled on the falling edge.
// Backpressure: rk_ready is exercised held high, held low for a stall, and randomly toggled.
module tb_boron_key_sequencer;

    localparam int NR = 25;

    logic        clk;
    logic        rst;
    logic [79:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic        abort;
    logic [63:0] rk_data;
    logic [4:0]  rk_index;
    logic        rk_last;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;

    int vectors;
    int miscompares;

    logic [3:0]  sbox_tbl [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                   4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
    logic [63:0] exp_keys [NR+1];

    boron_key_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .abort     (abort),
        .rk_data   (rk_data),
        .rk_index  (rk_index),
        .rk_last   (rk_last),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Software key schedule: rotate as shifts, S-box as a table lookup.
    function automatic logic [79:0] ref_upd(input logic [79:0] k, input int r);
        logic [79:0] t;
        logic [4:0]  rr;
        rr       = 5'(r);
        t        = (k << 13) | (k >> 67);
        t[3:0]   = sbox_tbl[t[3:0]];
        t[63:59] = t[63:59] ^ rr;
        return t;
    endfunction

    task automatic build_model(input logic [79:0] mk);
        logic [79:0] k;
        k = mk;
        for (int i = 0; i <= NR; i++) begin
            exp_keys[i] = k[63:0];
            k = ref_upd(k, i);
        end
    endtask

    // Offer a key for one edge; returns 1 ns after that edge.
    task automatic load_key(input logic [79:0] mk);
        key_in    = mk;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_last !== 1'b0 ||
            rk_data !== 64'h0 || rk_index !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: got kr=%b v=%b busy=%b last=%b data=%h idx=%0d required kr=1 v=0 busy=0 last=0 data=0 idx=0",
                     key_ready, rk_valid, busy, rk_last, rk_data, rk_index);
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got kr=%b v=%b required kr=1 v=0", key_ready, rk_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_key;
        build_model(80'h0);
        rk_ready = 1'b1;
        load_key(80'h0);
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            vectors++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || key_ready !== 1'b0 || rk_index !== 5'(i) ||
                rk_data !== exp_keys[i] || rk_last !== 1'(i == NR)) begin
                miscompares++;
                $display("FAIL zero_key_k%0d: got v=%b busy=%b kr=%b idx=%0d data=%h last=%b required v=1 busy=1 kr=0 idx=%0d data=%h last=%b",
                         i, rk_valid, busy, key_ready, rk_index, rk_data, rk_last, i, exp_keys[i], (i == NR));
            end
            if (i < 3) begin
                logic [63:0] fixed;
                fixed = (i == 0) ? 64'h0 : (i == 1) ? 64'hE : 64'h080000000001C00E;
                vectors++;
                if (rk_data !== fixed) begin
                    miscompares++;
                    $display("FAIL zero_key_const_k%0d: got %h required %h", i, rk_data, fixed);
                end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_key_done: got kr=%b v=%b busy=%b last=%b required kr=1 v=0 busy=0 last=0",
                     key_ready, rk_valid, busy, rk_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        logic [79:0] mk;
        int idx;
        int stall;
        mk = {$urandom(), $urandom(), 16'($urandom())};
        build_model(mk);
        rk_ready = 1'b1;
        load_key(mk);
        idx   = 0;
        stall = 0;
        while (idx <= NR) begin
            rk_ready = (idx == 3 && stall < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 5'(idx) || rk_data !== exp_keys[idx]) begin
                miscompares++;
                $display("FAIL backpressure_idx%0d_stall%0d: got v=%b idx=%0d data=%h required v=1 idx=%0d data=%h",
                         idx, stall, rk_valid, rk_index, rk_data, idx, exp_keys[idx]);
            end
            @(posedge clk);
            #1;
            if (rk_ready) idx++;
            else stall++;
        end
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_done: got kr=%b v=%b required kr=1 v=0", key_ready, rk_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_key_held_in_run;
        logic [79:0] other;
        other = {$urandom(), $urandom(), 16'($urandom())};
        build_model({80{1'b1}});
        rk_ready  = 1'b1;
        load_key({80{1'b1}});
        // Keep offering a different key for the whole run.
        key_in    = other;
        key_valid = 1'b1;
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            vectors++;
            if (rk_index !== 5'(i) || rk_data !== exp_keys[i] || key_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL key_held_k%0d: got idx=%0d data=%h kr=%b required idx=%0d data=%h kr=0",
                         i, rk_index, rk_data, key_ready, i, exp_keys[i]);
            end
            if (i == 0) begin
                vectors++;
                if (rk_data !== 64'hFFFFFFFFFFFFFFFF) begin
                    miscompares++;
                    $display("FAIL ones_k0: got %h required ffffffffffffffff", rk_data);
                end
            end
            if (i == 1) begin
                vectors++;
                if (rk_data[3:0] !== 4'h6 || rk_data[63:59] !== 5'h1F) begin
                    miscompares++;
                    $display("FAIL ones_k1_fields: got nib=%h top=%h required nib=6 top=1f",
                             rk_data[3:0], rk_data[63:59]);
                end
            end
            @(posedge clk);
            #1;
        end
        // Back in IDLE with key_valid still high: the held key is taken now.
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL key_held_idle: got kr=%b v=%b required kr=1 v=0", key_ready, rk_valid);
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rk_valid !== 1'b1 || rk_index !== 5'd0 || rk_data !== other[63:0]) begin
            miscompares++;
            $display("FAIL key_held_reload: got v=%b idx=%0d data=%h required v=1 idx=0 data=%h",
                     rk_valid, rk_index, rk_data, other[63:0]);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_abort;
        logic [79:0] ka;
        logic [79:0] kb;
        ka = {$urandom(), $urandom(), 16'($urandom())};
        kb = {$urandom(), $urandom(), 16'($urandom())};
        build_model(ka);
        rk_ready = 1'b1;
        load_key(ka);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        vectors++;
        if (rk_index !== 5'd10 || rk_data !== exp_keys[10] || rk_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_at_idx10: got idx=%0d data=%h v=%b required idx=10 data=%h v=1",
                     rk_index, rk_data, rk_valid, exp_keys[10]);
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_index !== 5'd0) begin
            miscompares++;
            $display("FAIL abort_to_idle: got kr=%b v=%b busy=%b idx=%0d required kr=1 v=0 busy=0 idx=0",
                     key_ready, rk_valid, busy, rk_index);
        end
        // abort beats key_valid in IDLE.
        @(posedge clk);
        #1;
        key_in    = kb;
        key_valid = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_blocks_load: got kr=%b v=%b busy=%b required kr=1 v=0 busy=0",
                     key_ready, rk_valid, busy);
        end
        @(posedge clk);
        #1;
        build_model(kb);
        load_key(kb);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 5'(i) || rk_data !== exp_keys[i]) begin
                miscompares++;
                $display("FAIL abort_reload_k%0d: got v=%b idx=%0d data=%h required v=1 idx=%0d data=%h",
                         i, rk_valid, rk_index, rk_data, i, exp_keys[i]);
            end
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_async_reset;
        build_model(80'h0);
        rk_ready = 1'b1;
        load_key(80'h0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_data !== 64'h0 ||
            rk_index !== 5'd0 || rk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_mid_run: got v=%b busy=%b kr=%b data=%h idx=%0d last=%b required v=0 busy=0 kr=1 data=0 idx=0 last=0",
                     rk_valid, busy, key_ready, rk_data, rk_index, rk_last);
        end
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_no_partial: got v=%b kr=%b required v=0 kr=1", rk_valid, key_ready);
        end
        @(posedge clk);
        #1;
        load_key(80'h0);
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            vectors++;
            if (rk_valid !== 1'b1 || rk_index !== 5'(i) || rk_data !== exp_keys[i] ||
                rk_last !== 1'(i == NR)) begin
                miscompares++;
                $display("FAIL post_reset_k%0d: got v=%b idx=%0d data=%h last=%b required v=1 idx=%0d data=%h last=%b",
                         i, rk_valid, rk_index, rk_data, rk_last, i, exp_keys[i], (i == NR));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random_keys;
        logic [79:0] mk;
        int idx;
        int cyc;
        for (int n = 0; n < 20; n++) begin
            mk = {$urandom(), $urandom(), 16'($urandom())};
            build_model(mk);
            load_key(mk);
            idx = 0;
            cyc = 0;
            while (idx <= NR && cyc < 400) begin
                rk_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                vectors++;
                if (rk_valid !== 1'b1 || rk_index !== 5'(idx) || rk_data !== exp_keys[idx] ||
                    rk_last !== 1'(idx == NR)) begin
                    miscompares++;
                    $display("FAIL random_key%0d_k%0d: got v=%b idx=%0d data=%h last=%b required v=1 idx=%0d data=%h last=%b",
                             n, idx, rk_valid, rk_index, rk_data, rk_last, idx, exp_keys[idx], (idx == NR));
                end
                @(posedge clk);
                #1;
                if (rk_ready) idx++;
                cyc++;
            end
            vectors++;
            if (idx <= NR) begin
                miscompares++;
                $display("FAIL random_key%0d_timeout: got %0d keys required %0d", n, idx, NR + 1);
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL random_key%0d_done: got kr=%b v=%b required kr=1 v=0", n, key_ready, rk_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        key_in      = '0;
        key_valid   = 1'b0;
        abort       = 1'b0;
        rk_ready    = 1'b0;
        test_reset();
        test_zero_key();
        test_backpressure();
        test_key_held_in_run();
        test_abort();
        test_async_reset();
        test_random_keys();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
